// File: rtl/div_nonrestoring_pkg.sv
// Shared multdiv definitions: operand width, divider state encoding and the
// two's-complement helper used for operand magnitudes and result sign fix-up.
package div_nonrestoring_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] NEG_ONE  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/div_nonrestoring_sll1.sv
// Logical left shift by one of the {partial remainder, quotient} vector,
// zero-filling bit 0; counterpart of the multiplier's arithmetic right shift.
module sll1_div
    import div_nonrestoring_pkg::*;
(
    input  logic [2*WIDTH:0] in_i,
    output logic [2*WIDTH:0] out_o
);

    assign out_o = {in_i[2*WIDTH-1:0], 1'b0};

endmodule

// File: rtl/div_nonrestoring.sv
// Iterative 32-bit signed non-restoring divider: one shift/add-or-subtract
// step per cycle, a final remainder correction and sign fix-up in FIX.
module div_nonrestoring
    import div_nonrestoring_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    div_state_e       state_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH:0]   p_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH:0]   d_q;
    logic             quo_neg_q;
    logic             rem_neg_q;
    logic             dbz_q;
    logic             ovf_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] remainder_q;
    logic             exception_q;
    logic             rdy_q;
    logic             busy_q;

    logic [2*WIDTH:0] pq_s;
    logic [2*WIDTH:0] pq_sh_s;
    logic [WIDTH:0]   p_sh_s;
    logic [WIDTH-1:0] q_sh_s;
    logic [WIDTH:0]   add_a_s;
    logic [WIDTH:0]   add_b_s;
    logic             add_cin_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] q_next_s;
    logic [WIDTH:0]   p_fix_s;
    logic [WIDTH-1:0] quot_s;
    logic [WIDTH-1:0] rem_s;
    logic [WIDTH-1:0] abs_a_s;
    logic [WIDTH-1:0] abs_b_s;
    logic             b_zero_s;
    logic             ovf_s;

    assign pq_s = {p_q, q_q};

    sll1_div u_sll1 (
        .in_i  (pq_s),
        .out_o (pq_sh_s)
    );

    assign p_sh_s = pq_sh_s[2*WIDTH:WIDTH];
    assign q_sh_s = pq_sh_s[WIDTH-1:0];

    // Shared adder operand select: RUN steps subtract when P >= 0, FIX restores a negative P
    always_comb begin
        add_a_s   = p_sh_s;
        add_b_s   = ~d_q;
        add_cin_s = 1'b1;
        if (state_q == FIX) begin
            add_a_s   = p_q;
            add_b_s   = d_q;
            add_cin_s = 1'b0;
        end else if (p_q[WIDTH]) begin
            add_b_s   = d_q;
            add_cin_s = 1'b0;
        end else begin
            add_b_s   = ~d_q;
            add_cin_s = 1'b1;
        end
    end

    assign sum_s    = add_a_s + add_b_s + {{WIDTH{1'b0}}, add_cin_s};
    assign q_next_s = q_sh_s | {{(WIDTH-1){1'b0}}, ~sum_s[WIDTH]};
    assign p_fix_s  = p_q[WIDTH] ? sum_s : p_q;
    assign quot_s   = quo_neg_q ? twos_neg(q_q) : q_q;
    assign rem_s    = rem_neg_q ? twos_neg(p_fix_s[WIDTH-1:0]) : p_fix_s[WIDTH-1:0];

    // |INT_MIN| stays 0x80000000, which is the correct unsigned magnitude
    assign abs_a_s  = data_operandA[WIDTH-1] ? twos_neg(data_operandA) : data_operandA;
    assign abs_b_s  = data_operandB[WIDTH-1] ? twos_neg(data_operandB) : data_operandB;
    assign b_zero_s = (data_operandB == ZERO_W);
    assign ovf_s    = (data_operandA == INT_MIN) && (data_operandB == NEG_ONE);

    // Divider FSM, datapath registers and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            count_q     <= CNT_ZERO;
            p_q         <= {(WIDTH+1){1'b0}};
            q_q         <= ZERO_W;
            d_q         <= {(WIDTH+1){1'b0}};
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            result_q    <= ZERO_W;
            remainder_q <= ZERO_W;
            exception_q <= 1'b0;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ctrl_DIV) begin
                        quo_neg_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        rem_neg_q <= data_operandA[WIDTH-1];
                        p_q       <= {(WIDTH+1){1'b0}};
                        q_q       <= abs_a_s;
                        d_q       <= {1'b0, abs_b_s};
                        count_q   <= CNT_ZERO;
                        dbz_q     <= b_zero_s;
                        ovf_q     <= ovf_s;
                        busy_q    <= 1'b1;
                        // A zero divisor goes straight to FIX, which reports it on the next edge
                        state_q   <= b_zero_s ? FIX : RUN;
                    end
                end
                RUN: begin
                    p_q     <= sum_s;
                    q_q     <= q_next_s;
                    count_q <= count_q + CNT_ONE;
                    if (count_q == CNT_LAST) begin
                        count_q <= CNT_ZERO;
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (dbz_q) begin
                        result_q    <= ZERO_W;
                        remainder_q <= ZERO_W;
                        exception_q <= 1'b1;
                    end else begin
                        p_q         <= p_fix_s;
                        result_q    <= quot_s;
                        remainder_q <= rem_s;
                        exception_q <= ovf_q;
                    end
                    rdy_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    count_q <= CNT_ZERO;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_result    = result_q;
    assign data_remainder = remainder_q;
    assign data_exception = exception_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_div_nonrestoring.sv
// Scoreboard bench for div_nonrestoring: stimulus pushes hand-computed results,
// a negedge monitor pops and compares whenever data_resultRDY is high.
module tb_div_nonrestoring;

    logic        clock;
    logic        reset_n;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic [31:0] rem;
        logic        exc;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic prev_rdy = 1'b0;

    div_nonrestoring dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every ready pulse against the oldest expected entry
    always @(negedge clock) begin
        if (data_resultRDY) begin
            check("rdy_not_back_to_back", {31'd0, prev_rdy}, 32'd0);
            check("busy_low_at_rdy", {31'd0, busy}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready pulse expected none (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, data_result, e.res);
                check({e.name, "_remainder"}, data_remainder, e.rem);
                check({e.name, "_exception"}, {31'd0, data_exception}, {31'd0, e.exc});
                check({e.name, "_latency"}, cyc, e.due);
            end
        end
        prev_rdy = data_resultRDY;
    end

    // Drive one start pulse (call at a negedge) and queue its expected response
    task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [31:0] rem, input logic exc);
        exp_t e;
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        e.res  = res;
        e.rem  = rem;
        e.exc  = exc;
        e.due  = cyc + ((b == 32'd0) ? 2 : 34);
        e.name = name;
        sb.push_back(e);
        @(negedge clock);
        ctrl_DIV = 1'b0;
        check({name, "_busy_rise"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check({name, "_drained"}, sb.size(), 32'd0);
        @(negedge clock);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        repeat (3) @(negedge clock);
        check("reset_result", data_result, 32'd0);
        check("reset_remainder", data_remainder, 32'd0);
        check("reset_exception", {31'd0, data_exception}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        issue("p100_d7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        drain("p100_d7");
        issue("m100_d7", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        drain("m100_d7");
        issue("p100_m7", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0);
        drain("p100_m7");
        issue("div_zero", 32'd7, 32'd0, 32'd0, 32'd0, 1'b1);
        drain("div_zero");
        issue("p9_d3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
        drain("p9_d3");
        issue("intmin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1);
        drain("intmin_m1");
        issue("intmin_p1", 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0);
        drain("intmin_p1");
        issue("big", 32'h7FFF_FFFF, 32'h0001_0000, 32'h0000_7FFF, 32'h0000_FFFF, 1'b0);
        drain("big");

        // Start pulse sampled at E10 of a running divide must be ignored
        issue("busy_ign", 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
        repeat (9) @(negedge clock);
        data_operandA = 32'd5;
        data_operandB = 32'd5;
        ctrl_DIV      = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        drain("busy_ign");
        repeat (40) @(negedge clock);

        // Back-to-back: second start presented during the ready cycle
        issue("b2b_first", 32'd50, 32'hFFFF_FFF8, 32'hFFFF_FFFA, 32'd2, 1'b0);
        begin
            int n;
            n = 0;
            while (!data_resultRDY && n < 100) begin
                @(negedge clock);
                n++;
            end
            check("b2b_rdy_seen", {31'd0, data_resultRDY}, 32'd1);
        end
        issue("b2b_second", 32'd17, 32'd5, 32'd3, 32'd2, 1'b0);
        drain("b2b_second");

        // Reset after E20 aborts the divide with no ready pulse
        issue("aborted", 32'd123456, 32'd3, 32'd41152, 32'd0, 1'b0);
        repeat (20) @(negedge clock);
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("abort_result", data_result, 32'd0);
        check("abort_remainder", data_remainder, 32'd0);
        check("abort_exception", {31'd0, data_exception}, 32'd0);
        check("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        check("abort_no_rdy_busy", {31'd0, busy}, 32'd0);

        issue("m1_d2", 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF, 1'b0);
        drain("m1_d2");
        repeat (5) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
